// File: rtl/uart_echo_fifo.sv
// Purpose : buffered UART echo; RX bytes are folded, queued in a FIFO and replayed to TX via start/busy handshake.
// Latency : 2 clk from an rx_valid strobe into an empty FIFO to tx_start (idle transmitter).
// Backpr. : tx_busy stalls the drain; a full FIFO refuses the push and counts it as a drop.
//
// Ports: clk/rst_n (async active-low), rx_data/rx_valid/rx_ferr from UART RX,
//        tx_start/tx_data/tx_busy to UART TX, fifo_count occupancy, overflow/drop_cnt/ferr_cnt
//        sticky statistics cleared by clear_stats.

// Generic synchronous FIFO: AW-bit wrapping pointers plus a separate occupancy counter.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_en   = pop_vld && !empty;
    assign wr_en   = push_vld && (!full || rd_en);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_echo_fifo #(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 16,
    parameter  int CASE_MODE = 0,
    parameter  int CRLF_EN   = 1,
    parameter  int DROP_FERR = 1,
    parameter  int CNT_W     = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_ferr,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic [AW:0]       fifo_count,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  ferr_cnt,
    input  logic              clear_stats
);
    localparam logic [DATA_W-1:0] CHR_CR = DATA_W'('h0D);
    localparam logic [DATA_W-1:0] CHR_LF = DATA_W'('h0A);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    state_t            state;
    logic              lf_pend;
    logic [DATA_W-1:0] fold_dat;
    logic [DATA_W-1:0] head_dat;
    logic              push_vld;
    logic              pop_vld;
    logic              fifo_full;
    logic              fifo_empty;
    logic              lost;

    // Folding happens before the write so the FIFO already holds what will be echoed.
    always_comb begin
        fold_dat = rx_data;
        if (DATA_W == 8) begin
            if (CASE_MODE == 1 && rx_data >= DATA_W'('h61) && rx_data <= DATA_W'('h7A))
                fold_dat = rx_data - DATA_W'('h20);
            else if (CASE_MODE == 2 && rx_data >= DATA_W'('h41) && rx_data <= DATA_W'('h5A))
                fold_dat = rx_data + DATA_W'('h20);
        end
    end

    assign push_vld = rx_valid && !(rx_ferr && (DROP_FERR != 0));
    // Must match the FIFO branch of IDLE below exactly: a pending LF wins over the FIFO head.
    assign pop_vld  = (state == IDLE) && !lf_pend && !fifo_empty && !tx_busy;
    assign lost     = push_vld && fifo_full && !pop_vld;

    sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (fold_dat),
        .pop_vld  (pop_vld),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // tx_data only changes on a load in IDLE, so it stays stable for the whole character.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            lf_pend  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if ((lf_pend || !fifo_empty) && !tx_busy) begin
                        if (lf_pend) begin
                            tx_data <= CHR_LF;
                            lf_pend <= 1'b0;
                        end else begin
                            tx_data <= head_dat;
                        end
                        tx_start <= 1'b1;
                        state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                        if (CRLF_EN != 0 && tx_data == CHR_CR) lf_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky statistics; clear wins over a same-cycle increment, counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
            ferr_cnt <= '0;
        end else if (clear_stats) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
            ferr_cnt <= '0;
        end else begin
            if (lost) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
            if (rx_valid && rx_ferr && ferr_cnt != '1) ferr_cnt <= ferr_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_echo_fifo.sv
module tb_uart_echo_fifo;
    localparam int DEPTH    = 16;
    localparam int CHAR_LEN = 16;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ferr;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [15:0] ferr_cnt;
    logic        clear_stats;

    uart_echo_fifo #(
        .DATA_W(8), .DEPTH(DEPTH), .CASE_MODE(1), .CRLF_EN(1), .DROP_FERR(1), .CNT_W(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ferr     (rx_ferr),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .ferr_cnt    (ferr_cnt),
        .clear_stats (clear_stats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int errors;

    // UART TX model: captures every tx_start, then stays busy for CHAR_LEN+1 cycles.
    logic       hold;
    logic       busy_active;
    int         busy_left;
    logic [7:0] tx_cur;
    logic [7:0] tx_q[$];
    int         cnt_q[$];
    int         busy_viol;
    int         stable_err;

    initial begin
        tx_busy     = 1'b0;
        busy_active = 1'b0;
        busy_left   = 0;
        tx_cur      = 8'h00;
        busy_viol   = 0;
        stable_err  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_active = 1'b0;
                busy_left   = 0;
            end else if (tx_start) begin
                if (tx_busy) busy_viol++;
                tx_q.push_back(tx_data);
                cnt_q.push_back(int'(fifo_count));
                tx_cur      = tx_data;
                busy_active = 1'b1;
                busy_left   = CHAR_LEN;
            end else if (busy_active) begin
                if (tx_data != tx_cur) stable_err++;
                if (busy_left > 0) busy_left--;
                else busy_active = 1'b0;
            end
            tx_busy = busy_active || hold;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int tx_at(input int idx);
        if (idx < tx_q.size()) return int'(tx_q[idx]);
        return -1;
    endfunction

    function automatic int cnt_at(input int idx);
        if (idx < cnt_q.size()) return cnt_q[idx];
        return -1;
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic f);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_ferr  = f;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((fifo_count != 0 || tx_busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'(n < max_cyc), 32'd1);
        repeat (40) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] din;
        logic       ferr;
        logic [7:0] exp;
        int         n_echo;
    } vec_t;

    vec_t vecs[9];
    int   base;
    int   s0;
    int   exp_q[$];

    initial begin
        vecs[0] = '{8'h41, 1'b0, 8'h41, 1};
        vecs[1] = '{8'h61, 1'b0, 8'h41, 1};   // 'a' folds to 'A'
        vecs[2] = '{8'h7A, 1'b0, 8'h5A, 1};   // 'z' folds to 'Z'
        vecs[3] = '{8'h60, 1'b0, 8'h60, 1};   // just below 'a'
        vecs[4] = '{8'h7B, 1'b0, 8'h7B, 1};   // just above 'z'
        vecs[5] = '{8'h5A, 1'b0, 8'h5A, 1};
        vecs[6] = '{8'h20, 1'b0, 8'h20, 1};
        vecs[7] = '{8'hFF, 1'b0, 8'hFF, 1};
        vecs[8] = '{8'h42, 1'b1, 8'h00, 0};   // frame error: dropped

        checks      = 0;
        errors      = 0;
        hold        = 1'b0;
        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        rx_ferr     = 1'b0;
        clear_stats = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_ferr_cnt", 32'(ferr_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte: tx_start exactly 2 clk after the rx_valid strobe.
        base = tx_q.size();
        push_byte(8'h41, 1'b0);
        check("t1_count_after_push", 32'(fifo_count), 1);
        check("t1_no_early_start", 32'(tx_start), 0);
        @(negedge clk);
        check("t1_start", 32'(tx_start), 1);
        check("t1_tx_data", 32'(tx_data), 32'h41);
        check("t1_count_after_pop", 32'(fifo_count), 0);
        repeat (40) @(negedge clk);
        check("t1_one_start", 32'(tx_q.size() - base), 1);

        // Single-byte vectors: folding, pass-through and frame-error drop.
        for (int i = 0; i < 9; i++) begin
            base = tx_q.size();
            push_byte(vecs[i].din, vecs[i].ferr);
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].n_echo));
            repeat (40) @(negedge clk);
            check($sformatf("vec%0d_n_echo", i), 32'(tx_q.size() - base), 32'(vecs[i].n_echo));
            if (tx_q.size() > base)
                check($sformatf("vec%0d_data", i), 32'(tx_at(base)), 32'(vecs[i].exp));
        end
        check("t5_ferr_cnt", 32'(ferr_cnt), 1);
        check("t5_count", 32'(fifo_count), 0);

        // clear_stats beats a same-cycle frame-error increment.
        @(negedge clk);
        rx_data     = 8'h43;
        rx_valid    = 1'b1;
        rx_ferr     = 1'b1;
        clear_stats = 1'b1;
        @(negedge clk);
        rx_valid    = 1'b0;
        rx_ferr     = 1'b0;
        clear_stats = 1'b0;
        check("t5_ferr_cleared", 32'(ferr_cnt), 0);
        check("t5_overflow_cleared", 32'(overflow), 0);

        // "a{Z" back to back.
        base = tx_q.size();
        push_byte(8'h61, 1'b0);
        push_byte(8'h7B, 1'b0);
        push_byte(8'h5A, 1'b0);
        drain(200);
        check("t3_len", 32'(tx_q.size() - base), 3);
        check("t3_b0", 32'(tx_at(base)), 32'h41);
        check("t3_b1", 32'(tx_at(base + 1)), 32'h7B);
        check("t3_b2", 32'(tx_at(base + 2)), 32'h5A);

        // CR then 'A' on consecutive cycles: LF injected without touching the FIFO.
        base = tx_q.size();
        @(negedge clk);
        rx_data  = 8'h0D;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_data  = 8'h41;
        @(negedge clk);
        rx_valid = 1'b0;
        drain(200);
        check("t4_len", 32'(tx_q.size() - base), 3);
        check("t4_b0", 32'(tx_at(base)), 32'h0D);
        check("t4_b1", 32'(tx_at(base + 1)), 32'h0A);
        check("t4_b2", 32'(tx_at(base + 2)), 32'h41);
        check("t4_count_at_lf", 32'(cnt_at(base + 1)), 1);
        check("t4_count_at_a", 32'(cnt_at(base + 2)), 0);

        // Overflow with the transmitter held busy.
        base = tx_q.size();
        hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < DEPTH + 3; i++) push_byte(8'(i), 1'b0);
        check("t2_count_full", 32'(fifo_count), DEPTH);
        check("t2_overflow", 32'(overflow), 1);
        check("t2_drop_cnt", 32'(drop_cnt), 3);
        check("t2_no_start_while_busy", 32'(tx_q.size() - base), 0);
        @(negedge clk);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        check("t2_overflow_cleared", 32'(overflow), 0);
        check("t2_drop_cleared", 32'(drop_cnt), 0);
        check("t2_count_kept", 32'(fifo_count), DEPTH);

        // Release busy and push into the full FIFO on the very cycle of the first pop.
        @(posedge clk);
        hold = 1'b0;
        @(negedge clk);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("t2_pop_push_start", 32'(tx_start), 1);
        check("t2_pop_push_count", 32'(fifo_count), DEPTH);
        check("t2_pop_push_no_drop", 32'(drop_cnt), 0);
        check("t2_pop_push_no_ovf", 32'(overflow), 0);
        drain(1000);
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(i);
            if (i == 8'h0D) exp_q.push_back(8'h0A);
        end
        exp_q.push_back(8'h55);
        check("t2_len", 32'(tx_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("t2_seq%0d", i), 32'(tx_at(base + i)), 32'(exp_q[i]));

        // Reset while WAIT_LO with 5 bytes queued.
        for (int i = 0; i < 6; i++) push_byte(8'h30 + 8'(i), 1'b0);
        check("t6_queued", 32'(fifo_count), 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_start_low", 32'(tx_start), 0);
        check("t6_count_cleared", 32'(fifo_count), 0);
        check("t6_tx_data_cleared", 32'(tx_data), 0);
        s0 = tx_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("t6_no_spurious_start", 32'(tx_q.size() - s0), 0);
        check("t6_count_after", 32'(fifo_count), 0);

        check("no_start_while_busy", 32'(busy_viol), 0);
        check("tx_data_stable", 32'(stable_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
